// File: rtl/ex_mem.sv
// ex_mem: execute-to-memory pipeline register with stall handling and
// holding registers for the two-cycle multiply-accumulate sequence.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam int unsigned DBL_DW = 64;
    localparam int unsigned CNT_W  = 2;

    logic [REG_AW-1:0] mem_wd_q,    mem_wd_d;
    logic              mem_wreg_q,  mem_wreg_d;
    logic [REG_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_whilo_q, mem_whilo_d;
    logic [REG_DW-1:0] mem_hi_q,    mem_hi_d;
    logic [REG_DW-1:0] mem_lo_q,    mem_lo_d;
    logic [DBL_DW-1:0] hilo_q,      hilo_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic ex_stall;
    logic mem_stall;

    // Only the execute and memory stall bits affect this stage.
    assign ex_stall  = stall[3];
    assign mem_stall = stall[4];

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Next-state selection: reset, then bubble, then pass, else hold.
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_whilo_d = mem_whilo_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;

        if (rst) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            hilo_d      = '0;
            cnt_d       = '0;
        end else if (ex_stall && !mem_stall) begin
            // Execute stalled, memory moving on: emit a NOP and keep the
            // partial accumulate product for execute's next cycle.
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
        end else if (!ex_stall) begin
            // Normal advance; the undefined ex-running/mem-stalled case lands here too.
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_whilo_d = ex_whilo;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            hilo_d      = '0;
            cnt_d       = '0;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk) begin
        mem_wd_q    <= mem_wd_d;
        mem_wreg_q  <= mem_wreg_d;
        mem_wdata_q <= mem_wdata_d;
        mem_whilo_q <= mem_whilo_d;
        mem_hi_q    <= mem_hi_d;
        mem_lo_q    <= mem_lo_d;
        hilo_q      <= hilo_d;
        cnt_q       <= cnt_d;
    end

    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_whilo = mem_whilo_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem.
`timescale 1ns/1ps
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int errors = 0;
    int checks = 0;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'h3f;
        set_ex(5'h1f, 1'b1, 32'hffff_ffff, 1'b1, 32'hffff_ffff, 32'hffff_ffff);
        hilo_i = 64'hffff_ffff_ffff_ffff; cnt_i = 2'b11;
        step();
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} !== 103'd0) begin
            errors++; $display("FAIL reset_mem: got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h expected all 0",
                               mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo);
        end
        checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            errors++; $display("FAIL reset_acc: got hilo_o=%h cnt_o=%0d expected 0 0", hilo_o, cnt_o);
        end
        step();
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o} !== 169'd0) begin
            errors++; $display("FAIL reset_second_cycle: got wdata=%h hilo_o=%h cnt_o=%0d expected 0",
                               mem_wdata, hilo_o, cnt_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        stall = 6'b000000; hilo_i = 64'h1234; cnt_i = 2'd2;
        set_ex(5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'hA, 32'hB);
        #1;
        checks++;
        if (mem_wdata !== 32'd0) begin
            errors++; $display("FAIL pass_no_comb_path: got mem_wdata=%h expected 00000000", mem_wdata);
        end
        step();
        checks++;
        if (mem_wd !== 5'd3 || mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL pass_gpr: got wd=%0d wreg=%b wdata=%h expected 3 1 12345678",
                               mem_wd, mem_wreg, mem_wdata);
        end
        checks++;
        if (mem_whilo !== 1'b1 || mem_hi !== 32'hA || mem_lo !== 32'hB) begin
            errors++; $display("FAIL pass_hilo: got whilo=%b hi=%h lo=%h expected 1 a b", mem_whilo, mem_hi, mem_lo);
        end
        checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            errors++; $display("FAIL pass_acc_clear: got hilo_o=%h cnt_o=%0d expected 0 0", hilo_o, cnt_o);
        end
    endtask

    task automatic test_bubble();
        stall = 6'b001000; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        set_ex(5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h11, 32'h22);
        step();
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} !== 103'd0) begin
            errors++; $display("FAIL bubble_nop: got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h expected all 0",
                               mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo);
        end
        checks++;
        if (hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1) begin
            errors++; $display("FAIL bubble_acc: got hilo_o=%h cnt_o=%0d expected 0000000100000002 1", hilo_o, cnt_o);
        end
    endtask

    task automatic test_hold();
        stall = 6'b000000; hilo_i = 64'd0; cnt_i = 2'd0;
        set_ex(5'd9, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
        step();
        checks++;
        if (mem_wdata !== 32'h55) begin
            errors++; $display("FAIL hold_setup: got mem_wdata=%h expected 00000055", mem_wdata);
        end
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(i + 20), 1'b0, 32'h1000 + 32'(i), 1'b1, 32'hF0 + 32'(i), 32'hE0);
            hilo_i = 64'hAAAA_0000 + 64'(i); cnt_i = 2'd3;
            step();
            checks++;
            if (mem_wdata !== 32'h55 || mem_wd !== 5'd9 || mem_wreg !== 1'b1 || mem_whilo !== 1'b0) begin
                errors++; $display("FAIL hold_mem[%0d]: got wd=%0d wreg=%b wdata=%h whilo=%b expected 9 1 00000055 0",
                                   i, mem_wd, mem_wreg, mem_wdata, mem_whilo);
            end
            checks++;
            if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
                errors++; $display("FAIL hold_acc[%0d]: got hilo_o=%h cnt_o=%0d expected 0 0", i, hilo_o, cnt_o);
            end
        end
        // Hold must also keep a latched nonzero accumulate state.
        stall = 6'b001000; hilo_i = 64'hCAFE_0000_BEEF_0001; cnt_i = 2'd1;
        step();
        stall = 6'b011000; hilo_i = 64'h0; cnt_i = 2'd0;
        step();
        checks++;
        if (hilo_o !== 64'hCAFE_0000_BEEF_0001 || cnt_o !== 2'd1) begin
            errors++; $display("FAIL hold_acc_nonzero: got hilo_o=%h cnt_o=%0d expected cafe0000beef0001 1", hilo_o, cnt_o);
        end
    endtask

    task automatic test_madd();
        stall = 6'b001000; hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2'd1;
        set_ex(5'd0, 1'b0, 32'h0, 1'b1, 32'h77, 32'h88);
        step();
        checks++;
        if (cnt_o !== 2'd1 || hilo_o !== 64'h0000_0003_0000_0004 || mem_whilo !== 1'b0) begin
            errors++; $display("FAIL madd_cycle1: got cnt_o=%0d hilo_o=%h whilo=%b expected 1 0000000300000004 0",
                               cnt_o, hilo_o, mem_whilo);
        end
        stall = 6'b000000; hilo_i = 64'h0; cnt_i = 2'd2;
        set_ex(5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2);
        step();
        checks++;
        if (mem_hi !== 32'h1 || mem_lo !== 32'h2 || mem_whilo !== 1'b1) begin
            errors++; $display("FAIL madd_result: got hi=%h lo=%h whilo=%b expected 1 2 1", mem_hi, mem_lo, mem_whilo);
        end
        checks++;
        if (cnt_o !== 2'd0 || hilo_o !== 64'd0) begin
            errors++; $display("FAIL madd_clear: got cnt_o=%0d hilo_o=%h expected 0 0", cnt_o, hilo_o);
        end
    endtask

    task automatic test_reset_mid();
        stall = 6'b001000; hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2'd1;
        step();
        checks++;
        if (cnt_o !== 2'd1) begin
            errors++; $display("FAIL rstmid_setup: got cnt_o=%0d expected 1", cnt_o);
        end
        rst = 1'b1; stall = 6'b000000;
        set_ex(5'd4, 1'b1, 32'h99, 1'b1, 32'h5, 32'h6);
        step();
        checks++;
        if (cnt_o !== 2'd0 || hilo_o !== 64'd0 || mem_wreg !== 1'b0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL rstmid_clear: got cnt_o=%0d hilo_o=%h wreg=%b wdata=%h expected 0 0 0 0",
                               cnt_o, hilo_o, mem_wreg, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_stall_bits();
        // Ex running with mem stalled is treated as a pass.
        stall = 6'b010000; hilo_i = 64'h5; cnt_i = 2'd1;
        set_ex(5'd12, 1'b1, 32'hA5A5_0000, 1'b0, 32'h3, 32'h4);
        step();
        checks++;
        if (mem_wd !== 5'd12 || mem_wdata !== 32'hA5A5_0000 || mem_hi !== 32'h3 || cnt_o !== 2'd0) begin
            errors++; $display("FAIL illegal_as_pass: got wd=%0d wdata=%h hi=%h cnt_o=%0d expected 12 a5a50000 3 0",
                               mem_wd, mem_wdata, mem_hi, cnt_o);
        end
        // Other stall bits do not matter.
        stall = 6'b100111;
        set_ex(5'd13, 1'b1, 32'h0F0F_0F0F, 1'b1, 32'h7, 32'h8);
        step();
        checks++;
        if (mem_wd !== 5'd13 || mem_wdata !== 32'h0F0F_0F0F || mem_lo !== 32'h8) begin
            errors++; $display("FAIL ignored_bits_pass: got wd=%0d wdata=%h lo=%h expected 13 0f0f0f0f 8",
                               mem_wd, mem_wdata, mem_lo);
        end
        stall = 6'b101111; hilo_i = 64'h0BAD; cnt_i = 2'd2;
        step();
        checks++;
        if (mem_wreg !== 1'b0 || mem_wdata !== 32'd0 || hilo_o !== 64'h0BAD || cnt_o !== 2'd2) begin
            errors++; $display("FAIL ignored_bits_bubble: got wreg=%b wdata=%h hilo_o=%h cnt_o=%0d expected 0 0 0bad 2",
                               mem_wreg, mem_wdata, hilo_o, cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h0000_0101; vals[1] = 32'h0000_0202; vals[2] = 32'h0000_0303;
        stall = 6'b000000; cnt_i = 2'd0; hilo_i = 64'd0;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(i + 1), 1'(i % 2), vals[i], 1'b0, 32'h0, 32'h0);
            step();
            checks++;
            if (mem_wd !== 5'(i + 1) || mem_wreg !== 1'(i % 2) || mem_wdata !== vals[i]) begin
                errors++; $display("FAIL b2b[%0d]: got wd=%0d wreg=%b wdata=%h expected %0d %b %h",
                                   i, mem_wd, mem_wreg, mem_wdata, i + 1, 1'(i % 2), vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_bubble();
        test_hold();
        test_madd();
        test_reset_mid();
        test_stall_bits();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory stage of the five-stage in-order core. On each clock edge it captures the execute-stage write-back request (GPR destination, enable and data, HI/LO write and values) and presents it to the memory stage, honouring the global stall vector so that stalls do not duplicate or drop instructions. It also holds the intermediate 64-bit product and cycle count for the two-cycle multiply-accumulate operations (madd, maddu, msub, msubu), feeding them back to the execute stage while it is stalled.

## Interface
- No parameters; all widths fixed (register address 5 bits, register data 32 bits, double data 64 bits, stall vector 6 bits).
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- stall  input  6  global stall vector; bit 3 = execute stalled, bit 4 = memory stalled
- ex_wd  input  5  execute-stage destination GPR
- ex_wreg  input  1  execute-stage GPR write enable
- ex_wdata  input  32  execute-stage GPR write data
- ex_whilo  input  1  execute-stage HI/LO write enable
- ex_hi  input  32  execute-stage HI value
- ex_lo  input  32  execute-stage LO value
- hilo_i  input  64  intermediate accumulate product from execute
- cnt_i  input  2  accumulate cycle count from execute
- mem_wd  output  5  destination GPR to memory stage
- mem_wreg  output  1  GPR write enable to memory stage
- mem_wdata  output  32  GPR write data to memory stage
- mem_whilo  output  1  HI/LO write enable to memory stage
- mem_hi  output  32  HI value to memory stage
- mem_lo  output  32  LO value to memory stage
- hilo_o  output  64  held intermediate product back to execute
- cnt_o  output  2  held cycle count back to execute

## Operation
- All outputs are registers updated only on the rising edge of clk; no combinational path from any input to any output.
- Priority per edge: rst, then bubble, then pass, then hold.
- Reset (rst=1): mem_wd=0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0, hilo_o=0, cnt_o=0.
- Bubble (stall[3]=1, stall[4]=0): execute stalled but memory proceeding. Memory-stage outputs loaded with the NOP value (all zero, both write enables 0). hilo_o<=hilo_i, cnt_o<=cnt_i (captures the first-cycle product of a multi-cycle accumulate).
- Pass (stall[3]=0): all mem_* outputs load the corresponding ex_* inputs. hilo_o<=0, cnt_o<=0 (accumulate sequence finished or none in progress).
- Hold (stall[3]=1, stall[4]=1): every output, including hilo_o and cnt_o, keeps its value.
- stall[3]=0 with stall[4]=1 is illegal (the stall controller never generates it); the block treats it as Pass.
- Accumulate sequence as seen by this block: cycle 1 execute asserts a stall and drives cnt_i=1 with the partial product; the register enters Bubble and latches them; cycle 2 execute reads hilo_o/cnt_o=1, completes, releases the stall; the register Passes the final HI/LO and clears hilo_o/cnt_o.
- Stall bits other than 3 and 4 are ignored.

## Timing
- Latency: exactly one cycle from ex_* to mem_* in Pass.
- Bubble inserts exactly one NOP per cycle it is active; an instruction held in execute is not passed until stall[3] drops.
- Reset takes effect on the first clk edge with rst=1; asserted mid-sequence it clears cnt_o/hilo_o and any in-flight write.
- Throughput: one instruction per cycle when stall=0.

## Test plan
- rst=1 for 2 cycles with all inputs at 0xFFFFFFFF-style nonzero values -> every output 0 after the first edge.
- stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=0x12345678, ex_whilo=1, ex_hi=0xA, ex_lo=0xB -> next cycle mem_* equal those values, hilo_o=0, cnt_o=0.
- stall=6'b001000 (bubble), hilo_i=64'h0000_0001_0000_0002, cnt_i=1, ex_wreg=1 -> next cycle mem_wreg=0, mem_whilo=0, mem_wdata=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=1.
- After Pass of wdata=0x55, apply stall=6'b011000 for 3 cycles while changing ex_* -> mem_wdata stays 0x55, hilo_o/cnt_o unchanged throughout.
- madd sequence: bubble cycle with cnt_i=1 then pass with ex_hi=0x1, ex_lo=0x2, ex_whilo=1 -> mem_hi=0x1, mem_lo=0x2, mem_whilo=1, cnt_o returns to 0.
- rst asserted in the cycle after a bubble latched cnt_o=1 -> cnt_o=0, hilo_o=0 next edge.
